// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : pipe_pkg
//  Purpose : Shared constants for the MIPS pipeline inter-stage registers:
//            Tnew encodings, stall-mode selectors, bubble field values and
//            a saturating-increment helper for the performance counters.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package pipe_pkg;

   // Tnew values produced at decode: cycles until the result is available
   localparam logic [1:0] T_PC  = 2'd0;
   localparam logic [1:0] T_ALU = 2'd1;
   localparam logic [1:0] T_DM  = 2'd2;

   // Stall behaviour selectors for the STALL_MODE parameter
   localparam int STALL_HOLD   = 0;
   localparam int STALL_BUBBLE = 1;

   // Field values of a bubble (non-instruction slot)
   localparam logic       C_BUBBLE_VALID    = 1'b0;
   localparam logic       C_BUBBLE_REGWRITE = 1'b0;

   localparam int         CNT_W = 32;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_perf_cnt.sv
`default_nettype none
// ============================================================================
//  Module  : pipe_perf_cnt
//  Purpose : 32-bit saturating event counter with synchronous clear.
//            Clear has priority over increment.
//  Ports   : clk   - clock
//            clr   - synchronous clear
//            inc   - count this cycle
//            cnt_o - counter value
//  Rev     : 1.0  initial release
// ============================================================================
module pipe_perf_cnt
   import pipe_pkg::*;
(
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (clr) begin
         r_cnt <= '0;
      end else if (inc) begin
         r_cnt <= sat_inc(r_cnt);
      end
   end

   assign cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module  : pipe_stage_reg
//  Purpose : Generic inter-stage register for the 5-stage MIPS pipeline.
//            Carries payload, valid, destination register, write enable and
//            Tnew. Priority per edge: reset > flush > stall > load.
//            Optional perf counters enabled by macro PIPE_STAGE_PERF_EN;
//            when undefined both counter ports read 0.
//  Ports   : clk, reset          - clock, sync active-high reset
//            stall, flush        - hazard unit controls
//            valid_i..tnew_i     - upstream entry
//            valid_o..tnew_o     - registered entry
//            fwd_rdy_o           - entry can forward its result now
//            stall_cnt_o         - cycles stalled (not flushed)
//            bubble_cnt_o        - bubbles written (flush/bubble-stall/invalid)
//  Rev     : 1.0  initial release
// ============================================================================
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W     = 128,
   parameter int ADDR_W     = 5,
   parameter int TNEW_W     = 2,
   parameter int DEC_TNEW   = 1,
   parameter int STALL_MODE = 0
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [ADDR_W-1:0] a3_i,
   input  logic              regwrite_i,
   input  logic [TNEW_W-1:0] tnew_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic [ADDR_W-1:0] a3_o,
   output logic              regwrite_o,
   output logic [TNEW_W-1:0] tnew_o,
   output logic              fwd_rdy_o,
   output logic [31:0]       stall_cnt_o,
   output logic [31:0]       bubble_cnt_o
);

   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic [ADDR_W-1:0] r_a3;
   logic              r_regwrite;
   logic [TNEW_W-1:0] r_tnew;

   logic              w_hold;
   logic              w_bubble;
   logic [TNEW_W-1:0] w_tnew_next;

   // Hold only applies in HOLD mode and only if not overridden by flush
   assign w_hold   = stall && !flush && (STALL_MODE == STALL_HOLD);

   // Bubble sources: flush, a bubble-mode stall, or an invalid upstream slot
   assign w_bubble = flush
                  || (stall && (STALL_MODE == STALL_BUBBLE))
                  || (!stall && !valid_i);

   // Saturating decrement: a Tnew of 0 stays 0
   assign w_tnew_next = ((DEC_TNEW != 0) && (tnew_i != '0))
                      ? tnew_i - TNEW_W'(1)
                      : tnew_i;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid    <= 1'b0;
         r_data     <= '0;
         r_a3       <= '0;
         r_regwrite <= 1'b0;
         r_tnew     <= '0;
      end else if (w_hold) begin
         r_valid    <= r_valid;
         r_data     <= r_data;
         r_a3       <= r_a3;
         r_regwrite <= r_regwrite;
         r_tnew     <= r_tnew;
      end else if (w_bubble) begin
         r_valid    <= C_BUBBLE_VALID;
         r_data     <= '0;
         r_a3       <= '0;
         r_regwrite <= C_BUBBLE_REGWRITE;
         r_tnew     <= '0;
      end else begin
         r_valid    <= 1'b1;
         r_data     <= data_i;
         r_a3       <= a3_i;
         r_regwrite <= regwrite_i;
         r_tnew     <= w_tnew_next;
      end
   end

   assign valid_o    = r_valid;
   assign data_o     = r_data;
   assign a3_o       = r_a3;
   assign regwrite_o = r_regwrite;
   assign tnew_o     = r_tnew;

   // $zero is never a forwarding source, and bubbles carry valid=0
   assign fwd_rdy_o  = r_valid && r_regwrite && (r_a3 != '0) && (r_tnew == '0);

`ifdef PIPE_STAGE_PERF_EN
   logic w_stall_inc;

   // Reset is handled by the counters' clear, which takes priority
   assign w_stall_inc = stall && !flush;

   pipe_perf_cnt u_stall_cnt (
      .clk   (clk),
      .clr   (reset),
      .inc   (w_stall_inc),
      .cnt_o (stall_cnt_o)
   );

   pipe_perf_cnt u_bubble_cnt (
      .clk   (clk),
      .clr   (reset),
      .inc   (w_bubble),
      .cnt_o (bubble_cnt_o)
   );
`else
   assign stall_cnt_o  = 32'd0;
   assign bubble_cnt_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module  : tb_pipe_stage_reg
//  Purpose : Self-checking bench for pipe_stage_reg. Three instances share
//            the stimulus: HOLD/decrement, BUBBLE/decrement, HOLD/no-dec.
//            Expected states come from a behavioural model, are queued when
//            stimulus is driven and popped after the clock edge.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_pipe_stage_reg;

   localparam int N = 3;

   typedef struct packed {
      logic         valid;
      logic [127:0] data;
      logic [4:0]   a3;
      logic         rw;
      logic [1:0]   tnew;
      logic [31:0]  sc;
      logic [31:0]  bc;
   } st_t;

   logic         clk = 1'b0;
   logic         reset, stall, flush, valid_i, regwrite_i;
   logic [127:0] data_i;
   logic [4:0]   a3_i;
   logic [1:0]   tnew_i;

   logic         valid_o    [N];
   logic [127:0] data_o     [N];
   logic [4:0]   a3_o       [N];
   logic         regwrite_o [N];
   logic [1:0]   tnew_o     [N];
   logic         fwd_rdy_o  [N];
   logic [31:0]  stall_cnt_o  [N];
   logic [31:0]  bubble_cnt_o [N];

   int   mode_c [N] = '{0, 1, 0};
   int   dec_c  [N] = '{1, 1, 0};
   st_t  model  [N];
   st_t  sb     [N][$];

   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(128), .ADDR_W(5), .TNEW_W(2), .DEC_TNEW(1), .STALL_MODE(0)) u_hold (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .valid_i(valid_i), .data_i(data_i), .a3_i(a3_i), .regwrite_i(regwrite_i), .tnew_i(tnew_i),
      .valid_o(valid_o[0]), .data_o(data_o[0]), .a3_o(a3_o[0]), .regwrite_o(regwrite_o[0]),
      .tnew_o(tnew_o[0]), .fwd_rdy_o(fwd_rdy_o[0]),
      .stall_cnt_o(stall_cnt_o[0]), .bubble_cnt_o(bubble_cnt_o[0]));

   pipe_stage_reg #(.DATA_W(128), .ADDR_W(5), .TNEW_W(2), .DEC_TNEW(1), .STALL_MODE(1)) u_bub (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .valid_i(valid_i), .data_i(data_i), .a3_i(a3_i), .regwrite_i(regwrite_i), .tnew_i(tnew_i),
      .valid_o(valid_o[1]), .data_o(data_o[1]), .a3_o(a3_o[1]), .regwrite_o(regwrite_o[1]),
      .tnew_o(tnew_o[1]), .fwd_rdy_o(fwd_rdy_o[1]),
      .stall_cnt_o(stall_cnt_o[1]), .bubble_cnt_o(bubble_cnt_o[1]));

   pipe_stage_reg #(.DATA_W(128), .ADDR_W(5), .TNEW_W(2), .DEC_TNEW(0), .STALL_MODE(0)) u_nodec (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .valid_i(valid_i), .data_i(data_i), .a3_i(a3_i), .regwrite_i(regwrite_i), .tnew_i(tnew_i),
      .valid_o(valid_o[2]), .data_o(data_o[2]), .a3_o(a3_o[2]), .regwrite_o(regwrite_o[2]),
      .tnew_o(tnew_o[2]), .fwd_rdy_o(fwd_rdy_o[2]),
      .stall_cnt_o(stall_cnt_o[2]), .bubble_cnt_o(bubble_cnt_o[2]));

   function automatic logic [31:0] inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Next-state model driven by the current stimulus values
   function automatic st_t model_next(input st_t s, input int mode, input int dec);
      st_t n;
      st_t bub;
      n   = s;
      bub = '0;
      bub.sc = s.sc;
      bub.bc = inc32(s.bc);
      if (reset) begin
         n = '0;
      end else begin
         if (stall && !flush) n.sc = inc32(s.sc);
         if (flush || (stall && mode == 1)) begin
            bub.sc = n.sc;
            n = bub;
         end else if (stall) begin
            // contents held; only the stall count moves
         end else if (!valid_i) begin
            n = bub;
         end else begin
            n.valid = 1'b1;
            n.data  = data_i;
            n.a3    = a3_i;
            n.rw    = regwrite_i;
            if (dec != 0 && tnew_i != 2'd0) n.tnew = tnew_i - 2'd1;
            else                            n.tnew = tnew_i;
         end
      end
      return n;
   endfunction

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      assert (act === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic step(input string tag, input logic rs, input logic fl, input logic st,
                       input logic v, input logic [127:0] d, input logic [4:0] a,
                       input logic w, input logic [1:0] t);
      st_t e;
      logic efwd;
      reset = rs; flush = fl; stall = st;
      valid_i = v; data_i = d; a3_i = a; regwrite_i = w; tnew_i = t;
      for (int i = 0; i < N; i++) begin
         model[i] = model_next(model[i], mode_c[i], dec_c[i]);
         sb[i].push_back(model[i]);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         e = sb[i].pop_front();
         efwd = e.valid && e.rw && (e.a3 != 5'd0) && (e.tnew == 2'd0);
         chk($sformatf("%s/u%0d/valid", tag, i), {127'd0, valid_o[i]}, {127'd0, e.valid});
         chk($sformatf("%s/u%0d/data",  tag, i), data_o[i], e.data);
         chk($sformatf("%s/u%0d/a3",    tag, i), {123'd0, a3_o[i]}, {123'd0, e.a3});
         chk($sformatf("%s/u%0d/rw",    tag, i), {127'd0, regwrite_o[i]}, {127'd0, e.rw});
         chk($sformatf("%s/u%0d/tnew",  tag, i), {126'd0, tnew_o[i]}, {126'd0, e.tnew});
         chk($sformatf("%s/u%0d/fwd",   tag, i), {127'd0, fwd_rdy_o[i]}, {127'd0, efwd});
`ifdef PIPE_STAGE_PERF_EN
         chk($sformatf("%s/u%0d/scnt", tag, i), {96'd0, stall_cnt_o[i]},  {96'd0, e.sc});
         chk($sformatf("%s/u%0d/bcnt", tag, i), {96'd0, bubble_cnt_o[i]}, {96'd0, e.bc});
`else
         chk($sformatf("%s/u%0d/scnt", tag, i), {96'd0, stall_cnt_o[i]},  128'd0);
         chk($sformatf("%s/u%0d/bcnt", tag, i), {96'd0, bubble_cnt_o[i]}, 128'd0);
`endif
      end
   endtask

   localparam logic [127:0] D_ABCD = 128'h0123_4567_89AB_CDEF_0011_2233_4455_ABCD;
   localparam logic [127:0] D_X    = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;

   initial begin
      for (int i = 0; i < N; i++) model[i] = '0;
      reset = 1'b1; stall = 1'b0; flush = 1'b0; valid_i = 1'b0;
      data_i = '0; a3_i = '0; regwrite_i = 1'b0; tnew_i = '0;

      // tag       rst   fl    st    v     data          a3     rw    tnew
      step("rst",  1'b1, 1'b0, 1'b0, 1'b0, D_X,          5'd3,  1'b1, 2'd1);
      step("ld2",  1'b0, 1'b0, 1'b0, 1'b1, D_ABCD,       5'd8,  1'b1, 2'd2);
      step("ld1",  1'b0, 1'b0, 1'b0, 1'b1, D_ABCD,       5'd8,  1'b1, 2'd1);
      // three-cycle stall with changing inputs
      step("st1",  1'b0, 1'b0, 1'b1, 1'b1, D_X,          5'd9,  1'b0, 2'd2);
      step("st2",  1'b0, 1'b0, 1'b1, 1'b0, 128'd7,       5'd10, 1'b1, 2'd0);
      step("st3",  1'b0, 1'b0, 1'b1, 1'b1, 128'd9,       5'd11, 1'b1, 2'd3);
      step("ld3",  1'b0, 1'b0, 1'b0, 1'b1, D_X,          5'd31, 1'b1, 2'd3);
      // flush wins over a simultaneous stall
      step("flst", 1'b0, 1'b1, 1'b1, 1'b1, D_ABCD,       5'd4,  1'b1, 2'd0);
      step("a3z",  1'b0, 1'b0, 1'b0, 1'b1, D_ABCD,       5'd0,  1'b1, 2'd0);
      step("tn0",  1'b0, 1'b0, 1'b0, 1'b1, D_X,          5'd5,  1'b1, 2'd0);
      step("nowr", 1'b0, 1'b0, 1'b0, 1'b1, D_X,          5'd5,  1'b0, 2'd0);
      step("inv",  1'b0, 1'b0, 1'b0, 1'b0, D_X,          5'd6,  1'b1, 2'd0);
      step("fl",   1'b0, 1'b1, 1'b0, 1'b1, D_X,          5'd6,  1'b1, 2'd0);
      // reset in the middle of a two-cycle hold stall
      step("ld4",  1'b0, 1'b0, 1'b0, 1'b1, D_ABCD,       5'd12, 1'b1, 2'd1);
      step("hs1",  1'b0, 1'b0, 1'b1, 1'b1, D_X,          5'd13, 1'b1, 2'd2);
      step("hsrs", 1'b1, 1'b0, 1'b1, 1'b1, D_X,          5'd13, 1'b1, 2'd2);
      step("hs2",  1'b0, 1'b0, 1'b1, 1'b1, D_X,          5'd14, 1'b1, 2'd2);

      // short pseudo-random tail
      for (int k = 0; k < 24; k++) begin
         step("rnd", 1'b0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 4) != 0),
              {$urandom, $urandom, $urandom, $urandom},
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic inter-stage register for the 5-stage MIPS pipeline. One instance per boundary (F/D, D/E, E/M, M/W) replaces the hand-written per-stage registers.
- Carries an opaque payload plus a valid bit, destination register, write-enable and Tnew hazard field.
- Tnew counts down as the instruction advances. Stall and flush behaviour is selectable per instance.
- Emits a forwarding-ready flag consumed by the hazard/forwarding unit.

Parameters:
- DATA_W, 128, payload width in bits (PC, instr, control bundle packed by the instantiator).
- ADDR_W, 5, destination register address width.
- TNEW_W, 2, Tnew field width.
- DEC_TNEW, 1, 1 = decrement Tnew (saturating at 0) on load; 0 = pass Tnew unchanged.
- STALL_MODE, 0, 0 = HOLD (stall keeps contents); 1 = BUBBLE (stall loads a bubble).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  stall request from hazard unit.
- flush  in  1  squash request; inserts a bubble.
- valid_i  in  1  upstream entry is a real instruction.
- data_i  in  DATA_W  upstream payload.
- a3_i  in  ADDR_W  upstream destination register.
- regwrite_i  in  1  upstream register-write enable.
- tnew_i  in  TNEW_W  upstream Tnew.
- valid_o  out  1  registered valid.
- data_o  out  DATA_W  registered payload.
- a3_o  out  ADDR_W  registered destination.
- regwrite_o  out  1  registered write enable.
- tnew_o  out  TNEW_W  registered Tnew.
- fwd_rdy_o  out  1  combinational: valid_o & regwrite_o & (a3_o!=0) & (tnew_o==0).
- stall_cnt_o  out  32  stall-cycle counter (see Optional Feature).
- bubble_cnt_o  out  32  bubble-insert counter (see Optional Feature).

Behaviour:
- Reset values: all outputs 0 (valid_o, data_o, a3_o, regwrite_o, tnew_o, counters). Power-up initial state is also all 0.
- Latency: 1 cycle input to output on load.
- Per-edge priority: reset > flush > stall > load.
- Reset: all registers cleared. Reset asserted mid-stall discards held contents.
- Flush: write a bubble. A bubble is valid_o=0, data_o=0, a3_o=0, regwrite_o=0, tnew_o=0. Flush wins over simultaneous stall.
- Stall, STALL_MODE=0: every register holds its value. Tnew is not decremented while held.
- Stall, STALL_MODE=1: write a bubble. This is the D/E style.
- Load with valid_i=1:
  - valid_o<=1, data_o<=data_i, a3_o<=a3_i, regwrite_o<=regwrite_i.
  - tnew_o<=(DEC_TNEW && tnew_i!=0) ? tnew_i-1 : tnew_i.
- Load with valid_i=0: write a bubble, regardless of data_i, so invalid slots are deterministic.
- Tnew arithmetic: unsigned TNEW_W bits, saturating at 0, never wraps.
- fwd_rdy_o: never 1 for a3_o==0 or for a bubble.
- No handshake beyond stall. The instantiator drives the same stall to all upstream stages.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt_o increments each cycle with stall=1, flush=0, reset=0.
  - bubble_cnt_o increments each cycle a bubble is written by flush, BUBBLE-mode stall, or a valid_i=0 load. Reset does not count.
  - Both counters are 32-bit, saturate at 32'hFFFF_FFFF, and are cleared by reset.
- Undefined: counter logic absent; both ports tied to 0. Port list is unchanged.

Decomposition:
- Package pipe_pkg:
  - Tnew constants T_ALU=1, T_DM=2, T_PC=0.
  - STALL_HOLD=0, STALL_BUBBLE=1.
  - Bubble constant / default zero values.
- One sub-module, pipe_perf_cnt: 32-bit saturating counter with inc and synchronous clear. Instantiated twice under PIPE_STAGE_PERF_EN.

Test Plan:
- Reset then load valid_i=1, data_i=0x…ABCD, a3_i=8, regwrite_i=1, tnew_i=2, DEC_TNEW=1 -> next cycle valid_o=1, data_o=0x…ABCD, a3_o=8, tnew_o=1, fwd_rdy_o=0. With tnew_i=1 instead -> tnew_o=0, fwd_rdy_o=1.
- STALL_MODE=0, stall held 3 cycles while inputs change -> outputs frozen all 3 cycles, tnew_o unchanged, stall_cnt_o=3 (perf on).
- STALL_MODE=1, stall=1 for 1 cycle -> bubble: valid_o=0, data_o=0, fwd_rdy_o=0; bubble_cnt_o=1.
- flush=1 and stall=1 together in HOLD mode -> bubble written, not hold; bubble_cnt_o+1, stall_cnt_o unchanged.
- Load a3_i=0, regwrite_i=1, tnew_i=0 -> fwd_rdy_o=0. Load tnew_i=0 with DEC_TNEW=1 -> tnew_o=0 (no wrap to 3).
- reset asserted during a 2-cycle HOLD stall -> next edge all outputs 0 and counters 0. Without PIPE_STAGE_PERF_EN, counters read 0 throughout.
